// File: rtl/axis_pack_master.sv
// axis_pack_master: packs narrow result words into M_AXIS beats through a first-word-fall-through beat FIFO.
module axis_pack_master #(
  parameter int IN_WIDTH = 8,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear,
  input  logic [IN_WIDTH-1:0]                 in_data,
  input  logic                                in_valid,
  input  logic                                in_last,
  output logic                                in_ready,
  input  logic                                M_AXIS_TREADY,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TVALID,
  output logic                                M_AXIS_TLAST,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_count,
  output logic [CNT_WIDTH-1:0]                beat_count,
  output logic                                frame_done
);
  localparam int W = C_M_AXIS_TDATA_WIDTH;
  localparam int SB = W / 8;
  localparam int RATIO = W / IN_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = RATIO > 1 ? $clog2(RATIO) : 1;
  logic [W-1:0]  mem_data [FIFO_DEPTH];
  logic [SB-1:0] mem_strb [FIFO_DEPTH];
  logic          mem_last [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_next;
  logic [SW-1:0] slot;
  logic [W-1:0]  pack_data, push_data;
  logic [SB-1:0] pack_strb, push_strb;
  logic          accept, push, pop;
  assign accept = in_valid && in_ready;
  assign push = accept && (in_last || slot == SW'(RATIO - 1));
  assign pop = M_AXIS_TVALID && M_AXIS_TREADY;
  assign push_data = pack_data | (W'(in_data) << (slot * IN_WIDTH));
  assign push_strb = pack_strb | (SB'({(IN_WIDTH/8){1'b1}}) << (slot * (IN_WIDTH / 8)));
  assign count_next = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
  // Output word is the head entry; the FIFO storage itself is the output register.
  assign M_AXIS_TDATA = mem_data[rd_ptr];
  assign M_AXIS_TSTRB = mem_strb[rd_ptr];
  assign M_AXIS_TLAST = mem_last[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_strb[i] <= '0;
        mem_last[i] <= 1'b0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      slot <= '0;
      pack_data <= '0;
      pack_strb <= '0;
      in_ready <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
      beat_count <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      slot <= '0;
      pack_data <= '0;
      pack_strb <= '0;
      in_ready <= 1'b1;
      M_AXIS_TVALID <= 1'b0;
      beat_count <= '0;
      frame_done <= 1'b0;
    end else begin
      if (accept) begin
        slot <= push ? '0 : slot + 1'b1;
        pack_data <= push ? '0 : push_data;
        pack_strb <= push ? '0 : push_strb;
      end
      if (push) begin
        mem_data[wr_ptr] <= push_data;
        mem_strb[wr_ptr] <= push_strb;
        mem_last[wr_ptr] <= in_last;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        beat_count <= M_AXIS_TLAST ? '0 : beat_count + 1'b1;
      end
      frame_done <= pop && M_AXIS_TLAST;
      fifo_count <= count_next;
      M_AXIS_TVALID <= count_next != '0;
      in_ready <= count_next != (AW+1)'(FIFO_DEPTH);
    end
  end
endmodule

// File: tb/tb_axis_pack_master.sv
// tb_axis_pack_master: directed checks of packing, backpressure, clear, reset and RATIO=1.
module tb_axis_pack_master;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic tready = 1'b0, tvalid, tlast, frame_done;
  logic [31:0] tdata;
  logic [3:0] tstrb, fifo_count;
  logic [15:0] beat_count;
  logic [31:0] in_data1 = '0;
  logic in_valid1 = 1'b0, in_last1 = 1'b0, in_ready1;
  logic tready1 = 1'b0, tvalid1, tlast1, frame_done1;
  logic [31:0] tdata1;
  logic [3:0] tstrb1, fifo_count1;
  logic [15:0] beat_count1;
  int checks = 0, failures = 0;
  axis_pack_master dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .M_AXIS_TREADY(tready), .M_AXIS_TDATA(tdata),
    .M_AXIS_TSTRB(tstrb), .M_AXIS_TVALID(tvalid), .M_AXIS_TLAST(tlast),
    .fifo_count(fifo_count), .beat_count(beat_count), .frame_done(frame_done));
  axis_pack_master #(.IN_WIDTH(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data1), .in_valid(in_valid1),
    .in_last(in_last1), .in_ready(in_ready1), .M_AXIS_TREADY(tready1), .M_AXIS_TDATA(tdata1),
    .M_AXIS_TSTRB(tstrb1), .M_AXIS_TVALID(tvalid1), .M_AXIS_TLAST(tlast1),
    .fifo_count(fifo_count1), .beat_count(beat_count1), .frame_done(frame_done1));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    in_data = d;
    in_last = l;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      step;
      n++;
    end
    if (n == 100) chk("send_timeout", 64'(in_ready), 64'd1);
    step;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  function automatic logic [7:0] bp_word(input int i);
    return i < 4 ? 8'((i + 1) * 17) : 8'(i);
  endfunction
  initial begin
    logic acc;
    int wi, bi, maxc;
    step;
    step;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_beat_count", 64'(beat_count), 64'd0);
    rst_n = 1'b1;
    step;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    // full 4-word frame
    tready = 1'b1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    chk("pk_tvalid", 64'(tvalid), 64'd1);
    chk("pk_tdata", 64'(tdata), 64'h44332211);
    chk("pk_tstrb", 64'(tstrb), 64'hF);
    chk("pk_tlast", 64'(tlast), 64'd1);
    chk("pk_fd_early", 64'(frame_done), 64'd0);
    step;
    chk("pk_fd", 64'(frame_done), 64'd1);
    chk("pk_tvalid_off", 64'(tvalid), 64'd0);
    step;
    chk("pk_fd_off", 64'(frame_done), 64'd0);
    // partial final beat
    tready = 1'b0;
    for (int i = 1; i <= 6; i++) send(8'(i * 17), i == 6);
    chk("pt_count", 64'(fifo_count), 64'd2);
    chk("pt_b1_data", 64'(tdata), 64'h44332211);
    chk("pt_b1_strb", 64'(tstrb), 64'hF);
    chk("pt_b1_last", 64'(tlast), 64'd0);
    tready = 1'b1;
    step;
    chk("pt_bc1", 64'(beat_count), 64'd1);
    chk("pt_b2_data", 64'(tdata), 64'h00006655);
    chk("pt_b2_strb", 64'(tstrb), 64'h3);
    chk("pt_b2_last", 64'(tlast), 64'd1);
    step;
    chk("pt_bc0", 64'(beat_count), 64'd0);
    chk("pt_fd", 64'(frame_done), 64'd1);
    // backpressure fills the FIFO
    tready = 1'b0;
    for (int i = 0; i < 32; i++) send(bp_word(i), 1'b0);
    chk("bp_count", 64'(fifo_count), 64'd8);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    in_data = bp_word(32);
    in_valid = 1'b1;
    step;
    step;
    chk("bp_hold_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_data", 64'(tdata), 64'h44332211);
    tready = 1'b1;
    acc = 1'b0;
    for (int b = 0; b < 8; b++) begin
      chk("bp_drain_valid", 64'(tvalid), 64'd1);
      chk("bp_drain_data", 64'(tdata), 64'({bp_word(4*b+3), bp_word(4*b+2), bp_word(4*b+1), bp_word(4*b)}));
      if (in_valid && in_ready) acc = 1'b1;
      step;
      if (acc) in_valid = 1'b0;
    end
    chk("bp_w33_acc", 64'(acc), 64'd1);
    chk("bp_empty", 64'(fifo_count), 64'd0);
    chk("bp_bc8", 64'(beat_count), 64'd8);
    send(bp_word(33), 1'b0);
    send(bp_word(34), 1'b0);
    send(bp_word(35), 1'b1);
    chk("bp_tail_data", 64'(tdata), 64'h23222120);
    chk("bp_tail_last", 64'(tlast), 64'd1);
    step;
    chk("bp_bc0", 64'(beat_count), 64'd0);
    chk("bp_fd", 64'(frame_done), 64'd1);
    // sustained streaming with simultaneous push and pop
    wi = 0;
    bi = 0;
    maxc = 0;
    for (int c = 0; c < 80 && (wi < 40 || tvalid); c++) begin
      in_valid = wi < 40;
      in_data = 8'(wi + 128);
      in_last = wi == 39;
      if (tvalid) begin
        chk("ss_data", 64'(tdata), 64'({8'(4*bi+131), 8'(4*bi+130), 8'(4*bi+129), 8'(4*bi+128)}));
        bi++;
      end
      if (in_valid && in_ready) wi++;
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      step;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("ss_beats", 64'(bi), 64'd10);
    chk("ss_maxcount", 64'(maxc), 64'd1);
    step;
    // clear mid-frame
    for (int i = 0; i < 4; i++) send(8'(i), 1'b0);
    step;
    chk("cl_bc1", 64'(beat_count), 64'd1);
    tready = 1'b0;
    for (int i = 0; i < 14; i++) send(8'(i), 1'b0);
    chk("cl_pre_count", 64'(fifo_count), 64'd3);
    clear = 1'b1;
    step;
    clear = 1'b0;
    chk("cl_tvalid", 64'(tvalid), 64'd0);
    chk("cl_count", 64'(fifo_count), 64'd0);
    chk("cl_bc", 64'(beat_count), 64'd0);
    chk("cl_fd", 64'(frame_done), 64'd0);
    step;
    chk("cl_fd2", 64'(frame_done), 64'd0);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b0);
    send(8'hA4, 1'b1);
    chk("cl_next_data", 64'(tdata), 64'hA4A3A2A1);
    chk("cl_next_strb", 64'(tstrb), 64'hF);
    tready = 1'b1;
    step;
    chk("cl_next_fd", 64'(frame_done), 64'd1);
    // asynchronous reset mid-frame, then RATIO=1
    tready = 1'b0;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    in_data1 = 32'hA5A5A5A5;
    in_valid1 = 1'b1;
    step;
    in_valid1 = 1'b0;
    chk("r1_pre_valid", 64'(tvalid1), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_tvalid1", 64'(tvalid1), 64'd0);
    chk("ar_count1", 64'(fifo_count1), 64'd0);
    chk("ar_tdata1", 64'(tdata1), 64'd0);
    chk("ar_ready1", 64'(in_ready1), 64'd0);
    chk("ar_ready", 64'(in_ready), 64'd0);
    step;
    rst_n = 1'b1;
    step;
    chk("ar_rel_ready1", 64'(in_ready1), 64'd1);
    send(8'h77, 1'b1);
    chk("s0_data", 64'(tdata), 64'h00000077);
    chk("s0_strb", 64'(tstrb), 64'h1);
    chk("s0_last", 64'(tlast), 64'd1);
    in_data1 = 32'hA5A5A5A5;
    in_valid1 = 1'b1;
    step;
    in_data1 = 32'h5A5A5A5A;
    in_last1 = 1'b1;
    step;
    in_valid1 = 1'b0;
    in_last1 = 1'b0;
    chk("r1_count", 64'(fifo_count1), 64'd2);
    chk("r1_b1_data", 64'(tdata1), 64'hA5A5A5A5);
    chk("r1_b1_strb", 64'(tstrb1), 64'hF);
    chk("r1_b1_last", 64'(tlast1), 64'd0);
    tready1 = 1'b1;
    step;
    chk("r1_b2_data", 64'(tdata1), 64'h5A5A5A5A);
    chk("r1_b2_strb", 64'(tstrb1), 64'hF);
    chk("r1_b2_last", 64'(tlast1), 64'd1);
    chk("r1_bc", 64'(beat_count1), 64'd1);
    step;
    chk("r1_fd", 64'(frame_done1), 64'd1);
    chk("r1_bc0", 64'(beat_count1), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
